alu_mul_sequencer: RTL and testbench

- Multicycle shift-add multiplier that reuses the CPU's single shared ALU instead of adding a hardware multiplier.
- Sits between the EX stage and the ALU, with an operand/func mux in front of the ALU.
- When idle, EX-stage operands pass straight through to the ALU.
- While a multiply runs, the sequencer owns the ALU and stalls EX; it produces the low WORD_SIZE bits of A*B.

---
 rtl/alu_mul_sequencer_pkg.sv | 25 ++
 rtl/alu_mul_sequencer_if.sv | 14 +
 rtl/alu_mul_sequencer_mux.sv | 20 ++
 rtl/alu_mul_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU definitions: datapath width default and ALU function codes.
// Function codes are 4 bits wide (ALU_PASS=9); the func ports are still 3 bits.
package alu_mul_sequencer_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int FUNC_W            = 3;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'd0;
  localparam alu_op_t ALU_SUB  = 4'd1;
  localparam alu_op_t ALU_AND  = 4'd2;
  localparam alu_op_t ALU_OR   = 4'd3;
  localparam alu_op_t ALU_NOT  = 4'd4;
  localparam alu_op_t ALU_NEG  = 4'd5;
  localparam alu_op_t ALU_SHL  = 4'd6;
  localparam alu_op_t ALU_SHR  = 4'd7;
  localparam alu_op_t ALU_PASS = 4'd9;

  // Narrow a full op code to the width the ALU ports carry today.
  function automatic logic [FUNC_W-1:0] to_port_func(input alu_op_t op);
    return op[FUNC_W-1:0];
  endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/result bus between the ALU owner (master) and the shared ALU (slave).
interface alu_mul_sequencer_if
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
  logic [WORD_SIZE-1:0] alu_a;
  logic [WORD_SIZE-1:0] alu_b;
  logic [FUNC_W-1:0]    alu_func;
  logic [WORD_SIZE-1:0] alu_result;

  modport master (output alu_a, output alu_b, output alu_func, input  alu_result);
  modport slave  (input  alu_a, input  alu_b, input  alu_func, output alu_result);
endinterface

// File: rtl/alu_mul_sequencer_mux.sv
// 2:1 ownership mux in front of the shared ALU: sequencer operands or EX-stage operands.
module alu_operand_mux #(
  parameter int WORD_SIZE = 16,
  parameter int FUNC_W    = 3
) (
  input  logic                 sel_seq,
  input  logic [WORD_SIZE-1:0] seq_a,
  input  logic [WORD_SIZE-1:0] seq_b,
  input  logic [FUNC_W-1:0]    seq_func,
  input  logic [WORD_SIZE-1:0] ex_a,
  input  logic [WORD_SIZE-1:0] ex_b,
  input  logic [FUNC_W-1:0]    ex_func,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [FUNC_W-1:0]    alu_func
);
  assign alu_a    = sel_seq ? seq_a    : ex_a;
  assign alu_b    = sel_seq ? seq_b    : ex_b;
  assign alu_func = sel_seq ? seq_func : ex_func;
endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the CPU's shared ALU; yields the low WORD_SIZE bits of A*B.
// EX-stage operands pass through to the ALU whenever the sequencer is not busy.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WORD_SIZE-1:0] mul_a,
  input  logic [WORD_SIZE-1:0] mul_b,
  input  logic [WORD_SIZE-1:0] ex_a,
  input  logic [WORD_SIZE-1:0] ex_b,
  input  logic [FUNC_W-1:0]    ex_func,
  alu_mul_sequencer_if.master  alu,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] mcand_q, mcand_d;
  logic [WORD_SIZE-1:0] mplier_q, mplier_d;
  logic [WORD_SIZE-1:0] product_q, product_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WORD_SIZE-1:0] nm;
  logic [WORD_SIZE-1:0] seq_a, seq_b;
  logic [FUNC_W-1:0]    seq_func;
  logic                 accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    count_d   = count_q;
    seq_a     = '0;
    seq_b     = '0;
    seq_func  = to_port_func(ALU_ADD);
    nm        = mplier_q >> 1;
    accept    = start && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_ADD: begin
        seq_a    = acc_q;
        seq_b    = mcand_q;
        seq_func = to_port_func(ALU_ADD);
        acc_d    = alu.alu_result;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        seq_a    = mcand_q;
        seq_b    = '0;
        seq_func = to_port_func(ALU_SHL);
        mcand_d  = alu.alu_result;
        mplier_d = nm;
        count_d  = count_q + 1'b1;
        // count_q is the number of shifts already done, so this is the last bit position.
        if (nm == '0 || count_q == CNT_W'(WORD_SIZE - 1)) begin
          state_d   = S_DONE;
          product_d = acc_q;
        end else if (nm[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      acc_d    = '0;
      mcand_d  = mul_a;
      mplier_d = mul_b;
      count_d  = '0;
      if (mul_b == '0) begin
        state_d   = S_DONE;
        product_d = '0;
      end else if (mul_b[0]) begin
        state_d = S_ADD;
      end else begin
        state_d = S_SHIFT;
      end
    end

    // Flush wins over everything, including a same-cycle start; the last product is kept.
    if (abort) begin
      state_d   = S_IDLE;
      product_d = product_q;
    end
  end

  assign busy    = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

  alu_operand_mux #(
    .WORD_SIZE (WORD_SIZE),
    .FUNC_W    (FUNC_W)
  ) u_alu_operand_mux (
    .sel_seq  (busy),
    .seq_a    (seq_a),
    .seq_b    (seq_b),
    .seq_func (seq_func),
    .ex_a     (ex_a),
    .ex_b     (ex_b),
    .ex_func  (ex_func),
    .alu_a    (alu.alu_a),
    .alu_b    (alu.alu_b),
    .alu_func (alu.alu_func)
  );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU and a product scoreboard.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [15:0] mul_a, mul_b, ex_a, ex_b;
  logic [2:0]  ex_func;
  logic        busy, done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  alu_mul_sequencer_if #(.WORD_SIZE(16)) alu_if ();

  alu_mul_sequencer #(.WORD_SIZE(16), .CNT_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .ex_a    (ex_a),
    .ex_b    (ex_b),
    .ex_func (ex_func),
    .alu     (alu_if.master),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Reference ALU
  always_comb begin
    case (alu_if.alu_func)
      3'd0:    alu_if.alu_result = alu_if.alu_a + alu_if.alu_b;
      3'd1:    alu_if.alu_result = alu_if.alu_a - alu_if.alu_b;
      3'd2:    alu_if.alu_result = alu_if.alu_a & alu_if.alu_b;
      3'd3:    alu_if.alu_result = alu_if.alu_a | alu_if.alu_b;
      3'd4:    alu_if.alu_result = ~alu_if.alu_a;
      3'd5:    alu_if.alu_result = -alu_if.alu_a;
      3'd6:    alu_if.alu_result = alu_if.alu_a << 1;
      default: alu_if.alu_result = alu_if.alu_a >> 1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end else if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          chk("product", product, e.prod);
          chk("busy_cycles", busy_cnt, e.busy_cycles);
        end
        busy_cnt = 0;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic push_exp(input logic [15:0] p, input int bc);
    exp_t e;
    e.prod = p;
    e.busy_cycles = bc;
    sb.push_back(e);
  endtask

  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] p, input int bc);
    @(negedge clk);
    mul_a = a;
    mul_b = b;
    start = 1'b1;
    push_exp(p, bc);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_f [5];
    exp_f = '{3'd0, 3'd6, 3'd6, 3'd0, 3'd6};

    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    mul_a = '0; mul_b = '0;
    ex_a = '0; ex_b = '0; ex_func = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle pass-through: 7 - 2
    ex_a = 16'd7; ex_b = 16'd2; ex_func = 3'd1;
    #1;
    chk("pass_result", alu_if.alu_result, 16'd5);
    chk("pass_func", alu_if.alu_func, 3'd1);

    // 3*5 with state sequence tracked through the ALU func, EX inputs held at junk
    ex_a = 16'h5555; ex_b = 16'hAAAA; ex_func = 3'd7;
    @(negedge clk);
    mul_a = 16'd3; mul_b = 16'd5; start = 1'b1;
    push_exp(16'd15, 5);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("seq_busy", busy, 1);
      chk("seq_func", alu_if.alu_func, exp_f[i]);
      if (i == 0) begin
        chk("seq_alu_a", alu_if.alu_a, 16'd0);
        chk("seq_alu_b", alu_if.alu_b, 16'd3);
      end
      @(negedge clk);
    end
    chk("seq_done", done, 1);
    @(negedge clk);
    chk("pass_restored", alu_if.alu_a, 16'h5555);
    ex_a = '0; ex_b = '0; ex_func = '0;

    do_mul(16'h1234, 16'h0000, 16'h0000, 0);
    do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 32);
    do_mul(16'h0100, 16'h0100, 16'h0000, 10);
    do_mul(16'd6,    16'd7,    16'd42,   6);

    // Abort in the third busy cycle of 3*5: no done, product stays 42
    @(negedge clk);
    mul_a = 16'd3; mul_b = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 16'd42);
    repeat (3) @(negedge clk);
    do_mul(16'd4, 16'd4, 16'd16, 4);

    // Back-to-back: start accepted in the DONE cycle of 2*3
    @(negedge clk);
    mul_a = 16'd2; mul_b = 16'd3; start = 1'b1;
    push_exp(16'd6, 4);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    mul_a = 16'd5; mul_b = 16'd7; start = 1'b1;
    push_exp(16'd35, 6);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done();
    @(negedge clk);

    // Asynchronous reset in the middle of a SHIFT
    @(negedge clk);
    mul_a = 16'hFFFF; mul_b = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_func", alu_if.alu_func, 3'd6);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_alu_a", alu_if.alu_a, 0);
    chk("rst_alu_func", alu_if.alu_func, 0);
    @(negedge clk);
    reset_n = 1'b1;

    do_mul(16'd9, 16'd9, 16'd81, 6);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
